key_schedule_iter: RTL

- Parametrised, word-serial AES key-expansion engine for AES-128/192/256. It replaces a chain of per-round expansion instances with one iterative datapath plus a round-key store.
- Accepts a cipher key on a start pulse and generates one 32-bit schedule word w[i] per clock.
- Holds all Nr+1 round keys and serves any one of them through an indexed, registered read port to the round datapath.

---
 rtl/key_schedule_iter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_schedule_iter.sv
// Word-serial AES key expansion (AES-128/192/256): one schedule word per clock,
// with a registered, indexed read port serving whole round keys.
module key_schedule_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                done,
    output logic                key_ready,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("key_schedule_iter: KEY_BITS must be 128, 192 or 256");
    end

    // Forward S-box, row-major; entry x sits at bits [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  wi;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic        done_q;
    logic        load;
    logic        last;
    logic [31:0] w [NW];
    logic [31:0] prev_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [5:0]  rk_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = EXPAND;
                    load       = 1'b1;
                end
            end
            EXPAND: begin
                if (wi == 6'(NW - 1)) begin
                    state_next = DONE;
                    last       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy      = (state == EXPAND);
        key_ready = (state == DONE);
        done      = done_q;
    end

    // One S-box bank serves both the RotWord path (phase 0) and the AES-256 mid-key path.
    always_comb begin
        prev_word = w[wi - 6'd1];
        sub_in    = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                     sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && phase == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = prev_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wi     <= 6'd0;
            phase  <= 3'd0;
            rcon   <= 8'h01;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                wi    <= 6'(NK);
                phase <= 3'd0;
                rcon  <= 8'h01;
            end else if (state == EXPAND) begin
                wi    <= wi + 6'd1;
                phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0) begin
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
            end
        end
    end

    // The word store carries no reset; its contents are only meaningful once key_ready is high.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key[KEY_BITS - 1 - 32 * k -: 32];
            end
        end else if (state == EXPAND) begin
            w[wi] <= w[wi - 6'(NK)] ^ temp;
        end
    end

    assign rk_base = {rk_idx, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_out <= 128'h0;
        end else if (rk_idx > 4'(NR)) begin
            rk_out <= 128'h0;
        end else begin
            rk_out <= {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
        end
    end

endmodule
